full_st0_tap_mem: RTL

FULL_ST0_TAP_MEM -- requirements
Module: full_st0_tap_mem

---
 rtl/full_st0_tap_mem_pkg.sv | 38 +++
 rtl/full_st0_tap_mem_if.sv | 30 +++
 rtl/full_st0_tap_mem_delay_pipe.sv | 47 ++++
 rtl/full_st0_tap_mem.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/full_st0_tap_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : full_st0_tap_mem_pkg
// Brief   : Shared types and constants for the tap-row memory.
// Revision: 1.0 - initial release
// ============================================================================
package full_st0_tap_mem_pkg;

    localparam int TAP_LANES    = 6;
    localparam int ERR_ROW_BASE = 12;
    localparam int c_lane_w     = 32;
    localparam int c_row_w      = TAP_LANES * c_lane_w;
    localparam int c_addr_w     = 5;

    typedef logic [c_lane_w-1:0] float_24_8;

    typedef struct packed {
        logic [c_addr_w-1:0] rd_address;
        logic                rd_vld;
        logic [c_addr_w-1:0] wr_address;
        logic                wr_vld;
        logic                sub_vld;
        logic [2:0]          sub_addr;
        float_24_8           sub_data;
        logic                inter;
        logic                inter_first;
    } tap_int_192_5;

    typedef enum logic [2:0] {
        CLR_IDLE = 3'd0,
        CLR_0    = 3'd1,
        CLR_1    = 3'd2,
        CLR_2    = 3'd3,
        CLR_3    = 3'd4
    } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/full_st0_tap_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : full_st0_tap_mem_if
// Brief   : Command / write-data / read-data bundle of the tap-row memory.
// Revision: 1.0 - initial release
// ============================================================================
interface full_st0_tap_mem_if;
    import full_st0_tap_mem_pkg::*;

    tap_int_192_5         tap_int;
    logic [c_row_w-1:0]   tap_int_wr_data;
    logic [c_row_w-1:0]   tap_int_rd_data;
    logic                 tap_int_rd_data_vld;

    modport master (
        output tap_int,
        output tap_int_wr_data,
        input  tap_int_rd_data,
        input  tap_int_rd_data_vld
    );

    modport slave (
        input  tap_int,
        input  tap_int_wr_data,
        output tap_int_rd_data,
        output tap_int_rd_data_vld
    );

endinterface
`default_nettype wire

// File: rtl/full_st0_tap_mem_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module  : full_delay_pipe
// Brief   : STAGES-deep valid/data delay line; data stages load only on valid.
// Revision: 1.0 - initial release
// ============================================================================
module full_delay_pipe #(
    parameter int WIDTH  = 192,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_vld,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_vld,
    output logic [WIDTH-1:0]      o_data
);

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_data [STAGES];

    // Gating data on valid makes the last stage hold its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_data[0] <= i_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[STAGES-1];
    assign o_data = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/full_st0_tap_mem.sv
`default_nettype none
// ============================================================================
// Module  : full_st0_tap_mem
// Brief   : DEPTH x 192-bit tap memory with lane writes, error-row clear FSM,
//           write-first pipelined reads and address checking.
// Revision: 1.0 - initial release
// ============================================================================
module full_st0_tap_mem
    import full_st0_tap_mem_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int DEPTH      = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    full_st0_tap_mem_if.slave  tap_if,
    output logic               clear_busy,
    output logic [7:0]         inter_wr_count,
    output logic               addr_err
);

    localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_addr_w:0] c_depth = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0] c_err_base = (c_addr_w+1)'(ERR_ROW_BASE);

    tap_int_192_5          w_cmd;
    logic [c_row_w-1:0]    r_mem [DEPTH];
    clr_state_e            r_state;
    clr_state_e            w_state_nxt;
    logic                  r_inter_q;
    logic                  r_inter_first_q;
    logic                  w_inter_rise;
    logic                  w_first_rise;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_lane_ok;
    logic                  w_wr_ok;
    logic                  w_wr_bad;
    logic                  w_rd_bad;
    logic [c_idx_w-1:0]    w_wr_idx;
    logic [c_idx_w-1:0]    w_rd_idx;
    logic [c_idx_w-1:0]    w_clr_idx;
    logic [1:0]            w_clr_off;
    logic [c_addr_w:0]     w_clr_row;
    logic                  w_clr_hit;
    logic [c_row_w-1:0]    w_wr_row;
    logic [c_row_w-1:0]    w_rd_row;
    logic                  w_pipe_vld;
    logic [c_row_w-1:0]    w_pipe_data;

    assign w_cmd         = tap_if.tap_int;
    assign w_inter_rise  = w_cmd.inter & ~r_inter_q;
    assign w_first_rise  = w_cmd.inter_first & ~r_inter_first_q;

    assign w_wr_in_range = {1'b0, w_cmd.wr_address} < c_depth;
    assign w_rd_in_range = {1'b0, w_cmd.rd_address} < c_depth;
    assign w_lane_ok     = w_cmd.sub_addr < 3'(TAP_LANES);
    assign w_wr_ok       = w_cmd.wr_vld & w_wr_in_range & (~w_cmd.sub_vld | w_lane_ok);
    assign w_wr_bad      = w_cmd.wr_vld & (~w_wr_in_range | (w_cmd.sub_vld & ~w_lane_ok));
    assign w_rd_bad      = w_cmd.rd_vld & ~w_rd_in_range;

    assign w_wr_idx      = w_cmd.wr_address[c_idx_w-1:0];
    assign w_rd_idx      = w_cmd.rd_address[c_idx_w-1:0];

    // A lane write merges into the currently stored row in the same cycle.
    always_comb begin
        w_wr_row = w_cmd.sub_vld ? r_mem[w_wr_idx] : tap_if.tap_int_wr_data;
        for (int l = 0; l < TAP_LANES; l++) begin
            if (w_cmd.sub_vld && (w_cmd.sub_addr == 3'(l))) begin
                w_wr_row[l*c_lane_w +: c_lane_w] = w_cmd.sub_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLR_0:   w_state_nxt = CLR_1;
            CLR_1:   w_state_nxt = CLR_2;
            CLR_2:   w_state_nxt = CLR_3;
            CLR_3:   w_state_nxt = CLR_IDLE;
            default: w_state_nxt = CLR_IDLE;
        endcase
        if (w_first_rise) begin
            w_state_nxt = CLR_0;
        end
    end

    always_comb begin
        w_clr_off = 2'd0;
        case (r_state)
            CLR_1:   w_clr_off = 2'd1;
            CLR_2:   w_clr_off = 2'd2;
            CLR_3:   w_clr_off = 2'd3;
            default: w_clr_off = 2'd0;
        endcase
    end

    assign w_clr_row  = c_err_base + {{(c_addr_w-1){1'b0}}, w_clr_off};
    assign w_clr_hit  = (r_state != CLR_IDLE) && (w_clr_row < c_depth);
    assign w_clr_idx  = w_clr_row[c_idx_w-1:0];
    assign clear_busy = (r_state != CLR_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= CLR_IDLE;
            r_inter_q       <= 1'b0;
            r_inter_first_q <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inter_q       <= w_cmd.inter;
            r_inter_first_q <= w_cmd.inter_first;
        end
    end

    // The clear is written after the external write so it wins on a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_mem[w_wr_idx] <= w_wr_row;
            end
            if (w_clr_hit) begin
                r_mem[w_clr_idx] <= '0;
            end
        end
    end

    // Read bypass mirrors the write priority: clear over write over storage.
    always_comb begin
        w_rd_row = r_mem[w_rd_idx];
        if (w_wr_ok && (w_cmd.wr_address == w_cmd.rd_address)) begin
            w_rd_row = w_wr_row;
        end
        if (w_clr_hit && (w_clr_row == {1'b0, w_cmd.rd_address})) begin
            w_rd_row = '0;
        end
        if (!w_rd_in_range) begin
            w_rd_row = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inter_wr_count <= 8'd0;
            addr_err       <= 1'b0;
        end else begin
            if (w_inter_rise) begin
                inter_wr_count <= 8'd0;
            end else if (w_cmd.inter && w_wr_ok && (inter_wr_count != 8'hFF)) begin
                inter_wr_count <= inter_wr_count + 8'd1;
            end
            if (w_wr_bad || w_rd_bad) begin
                addr_err <= 1'b1;
            end
        end
    end

    full_delay_pipe #(
        .WIDTH  (c_row_w),
        .STAGES (RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (reset),
        .i_vld  (w_cmd.rd_vld),
        .i_data (w_rd_row),
        .o_vld  (w_pipe_vld),
        .o_data (w_pipe_data)
    );

    assign tap_if.tap_int_rd_data_vld = w_pipe_vld;
    assign tap_if.tap_int_rd_data     = w_pipe_data;

endmodule
`default_nettype wire
